fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 90 +++++++++
 tb/tb_fp_add_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin arbiter sharing one external combinational fp32 adder among NREQ requesters.
// Define FPADD_ARB_SUB_EN to honour req_op as subtract (sign of B flipped before the adder).
module fp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*SIZE-1:0]    req_a,
  input  logic [NREQ*SIZE-1:0]    req_b,
  input  logic [NREQ-1:0]         req_op,
  output logic [SIZE-1:0]         add_a,
  output logic [SIZE-1:0]         add_b,
  input  logic [SIZE-1:0]         add_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [SIZE-1:0]         rsp_data
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_id;
  logic [IW-1:0]   idx;
  logic            gnt_any;
  logic            hs;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  // Walk downward so the nearest valid requester after ptr is the last one written.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = ptr + IW'(k);
      if (req_valid[idx]) begin
        gnt_id  = idx;
        gnt_any = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && gnt_any && !rst) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_id : '0;
  assign hs        = |(req_valid & req_ready);
  assign add_a     = a_q;
`ifdef FPADD_ARB_SUB_EN
  logic op_q;
  assign add_b = op_q ? {~b_q[SIZE-1], b_q[SIZE-2:0]} : b_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) op_q <= 1'b0;
    else if (state == IDLE && hs) op_q <= req_op[gnt_id];
`else
  logic unused_op;
  assign unused_op = ^req_op;
  assign add_b     = b_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          a_q    <= req_a[gnt_id*SIZE +: SIZE];
          b_q    <= req_b[gnt_id*SIZE +: SIZE];
          rsp_id <= gnt_id;
          ptr    <= gnt_id;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_data  <= add_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed checks of grant rotation, latency, hold, abort and subtract handling.
module tb_fp_add_arbiter;
  localparam int NREQ = 4;
  localparam int SIZE = 32;
  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic [NREQ-1:0]      req_op;
  logic [SIZE-1:0]      add_a;
  logic [SIZE-1:0]      add_b;
  logic [SIZE-1:0]      add_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [SIZE-1:0]      rsp_data;
  int total = 0;
  int bad   = 0;
  logic [31:0] held;
  fp_add_arbiter #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );
  always #5 clk = ~clk;
  // Stand-in adder: exact fp32 sums for the fp vectors used, integer sum for tagged payloads.
  function automatic logic [31:0] adder(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'hBF800000}: return 32'h40000000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      default:                      return a + b;
    endcase
  endfunction
  always_comb add_out = adder(add_a, add_b);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[i*SIZE +: SIZE] = a;
    req_b[i*SIZE +: SIZE] = b;
    req_op[i]             = op;
  endtask
  initial begin
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    req_valid = '0;
    tick;
    rst = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("basic_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    chk("basic_exec_valid", 32'(rsp_valid), 32'h0);
    chk("basic_exec_ready", 32'(req_ready), 32'h0);
    chk("basic_add_a", add_a, 32'h3F800000);
    tick;
    chk("basic_valid", 32'(rsp_valid), 32'h1);
    chk("basic_data", rsp_data, 32'h40400000);
    chk("basic_id", 32'(rsp_id), 32'h0);
    rsp_ready = 1'b1;
    tick;
    chk("basic_done", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b0;
    set_req(1, 32'h5, 32'h7, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("hold_grant", 32'(req_ready), 32'h2);
    tick;
    req_valid = '1;
    tick;
    held = rsp_data;
    chk("hold_data0", held, 32'hC);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_data", rsp_data, held);
      chk("hold_id", 32'(rsp_id), 32'h1);
      chk("hold_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    tick;
    chk("hold_release", 32'(rsp_valid), 32'h0);
    chk("hold_next", 32'(req_ready), 32'h4);
    req_valid = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 16 + 1), 32'h100, 1'b0);
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("rot_ready", 32'(req_ready), 32'(1 << (n % NREQ)));
      tick;
      tick;
      chk("rot_valid", 32'(rsp_valid), 32'h1);
      chk("rot_id", 32'(rsp_id), 32'(n % NREQ));
      chk("rot_data", rsp_data, 32'((n % NREQ) * 16 + 1 + 256));
      tick;
      chk("rot_one_cycle", 32'(rsp_valid), 32'h0);
    end
    req_valid = '0;
    set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("sub_grant", 32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
`ifdef FPADD_ARB_SUB_EN
    chk("sub_add_b", add_b, 32'hBF800000);
`else
    chk("sub_add_b", add_b, 32'h3F800000);
`endif
    tick;
`ifdef FPADD_ARB_SUB_EN
    chk("sub_data", rsp_data, 32'h40000000);
`else
    chk("sub_data", rsp_data, 32'h40800000);
`endif
    chk("sub_id", 32'(rsp_id), 32'h2);
    tick;
    set_req(3, 32'h12345678, 32'h1, 1'b0);
    req_valid = 4'b1000;
    #1;
    chk("drop_offer", 32'(req_ready), 32'h8);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("drop_valid", 32'(rsp_valid), 32'h0);
      chk("drop_add_a", add_a, 32'h40400000);
    end
    req_valid = 4'b0010;
    #1;
    chk("abort_grant", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(req_ready), 32'h0);
    chk("abort_valid_rst", 32'(rsp_valid), 32'h0);
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("abort_valid", 32'(rsp_valid), 32'h0);
    end
    req_valid = '1;
    #1;
    chk("abort_next", 32'(req_ready), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
